fetch_unit: RTL

Instruction fetch stage of the RiSC-16 core; sits directly upstream of the instruction decoder and supplies it one 16-bit instruction word per handshake. Owns the program counter and issues word-addressed reads to instruction memory over a req/ack handshake. Buffers returned words, with their PCs, in a small FIFO. Accepts branch/JALR redirects from execute, which flush all buffered and in-flight instructions.

---
 rtl/risc16_pkg.sv | 23 ++
 rtl/fetch_fifo.sv | 62 ++++++
 rtl/fetch_unit.sv | 71 +++++++
 3 files changed

// File: rtl/risc16_pkg.sv
// Shared RiSC-16 definitions: word type, opcodes, and the fetch-to-decode entry.
package risc16_pkg;
  localparam int WORD_W = 16;
  typedef logic [WORD_W-1:0] word_t;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_ADDI = 3'b001;
  localparam logic [2:0] OP_NAND = 3'b010;
  localparam logic [2:0] OP_LUI  = 3'b011;
  localparam logic [2:0] OP_SW   = 3'b100;
  localparam logic [2:0] OP_LW   = 3'b101;
  localparam logic [2:0] OP_BEQ  = 3'b110;
  localparam logic [2:0] OP_JALR = 3'b111;

  typedef struct packed {
    word_t pc;
    word_t instr;
  } fetch_entry_t;

  function automatic word_t pc_inc(input word_t pc);
    return pc + word_t'(1);
  endfunction
endpackage

// File: rtl/fetch_fifo.sv
// Fetch entry FIFO with a registered head; 1 cycle push-to-head, flush wins over push/pop.
// No backpressure of its own: the owner must not push while full.
module fetch_fifo
  import risc16_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  fetch_entry_t               push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output fetch_entry_t               head
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr, rd_nxt;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !flush && !full;
  assign do_pop  = pop && !flush && !empty;
  assign rd_nxt  = do_pop ? ptr_inc(rd_ptr) : rd_ptr;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // head tracks the entry at rd_nxt; a push into an emptying FIFO bypasses storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      rd_ptr <= rd_nxt;
      count  <= count + CW'(do_push) - CW'(do_pop);
      if (count == CW'(do_pop)) begin
        if (do_push) head <= push_data;
      end else begin
        head <= mem[rd_nxt];
      end
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// RiSC-16 fetch: PC, imem req/ack, redirect squash; ack in cycle N gives instr_valid in N+1.
// No new request while the FIFO is full; the head is held while instr_ready is low.
module fetch_unit
  import risc16_pkg::*;
#(
  parameter int                DEPTH    = 2,
  parameter logic [WORD_W-1:0] RESET_PC = 16'h0000
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [WORD_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [WORD_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [WORD_W-1:0] redirect_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [WORD_W-1:0] instr,
  output logic [WORD_W-1:0] instr_pc
);
  localparam int CW = $clog2(DEPTH + 1);

  word_t         pc, hold_addr;
  logic          drop, pending, ack, push, pop, full, empty;
  logic [CW-1:0] count;
  fetch_entry_t  new_entry, head;

  // An issued request cannot be retracted, so it stays up (at its old address) until acked.
  assign imem_req    = rst_n && ((count < CW'(DEPTH)) || pending);
  assign imem_addr   = drop ? hold_addr : pc;
  assign ack         = imem_req && imem_ack;
  assign push        = ack && !drop && !redirect_valid && !full;
  assign pop         = instr_valid && instr_ready;
  assign instr_valid = !empty;
  assign instr       = head.instr;
  assign instr_pc    = head.pc;
  assign new_entry   = '{pc: pc, instr: imem_rdata};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc        <= RESET_PC;
      hold_addr <= '0;
      drop      <= 1'b0;
      pending   <= 1'b0;
    end else begin
      pending <= imem_req && !imem_ack;
      if (redirect_valid) pc <= redirect_pc;
      else if (ack && !drop) pc <= pc_inc(pc);
      if (ack) begin
        drop <= 1'b0;
      end else if (redirect_valid && imem_req) begin
        drop <= 1'b1;
        if (!drop) hold_addr <= pc;
      end
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (new_entry),
    .pop       (pop),
    .flush     (redirect_valid),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .head      (head)
  );
endmodule
